// File: rtl/sa_result_collector_pkg.sv
// Shared types and sizing for the systolic-array result collector.
package sa_result_collector_pkg;

    localparam int unsigned ROWS   = 3;
    localparam int unsigned COLS   = 3;
    localparam int unsigned DW     = 16;
    localparam int unsigned NRES   = ROWS * COLS;
    localparam int unsigned NWORDS = 5;
    localparam int unsigned TLAST  = ROWS + COLS - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READY   = 2'd3
    } state_e;

    typedef logic [DW-1:0] res_t;
    typedef logic [31:0]   word_t;

    // Two results packed little end first into one bus word.
    function automatic word_t pack_word(input res_t lo, input res_t hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/sa_result_collector_if.sv
// Array-side capture inputs plus the strobe/ack read port of the collector.
interface sa_result_collector_if;
    import sa_result_collector_pkg::*;

    logic  start;
    logic  in_valid;
    res_t  out1;
    res_t  out2;
    res_t  out3;
    logic  rd_stb;
    logic  rd_ack;
    word_t rd_data;
    logic  busy;
    logic  ready;

    modport master (
        output start, in_valid, out1, out2, out3, rd_stb,
        input  rd_ack, rd_data, busy, ready
    );

    modport slave (
        input  start, in_valid, out1, out2, out3, rd_stb,
        output rd_ack, rd_data, busy, ready
    );

endinterface

// File: rtl/sa_result_collector_rd_port.sv
// Strobe/ack read port: one ack per strobe, word pointer and packing mux.
module sa_rd_port
    import sa_result_collector_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rd_stb,
    input  logic  serve,
    input  res_t  res [NRES],
    output logic  rd_ack,
    output word_t rd_data,
    output logic  last_ack
);

    logic        ack_q, ack_d;
    word_t       data_q, data_d;
    logic [2:0]  wp_q, wp_d;
    logic        last_q, last_d;
    word_t       word_sel;

    // Select the packed word addressed by the pointer.
    always_comb begin
        word_sel = '0;
        case (wp_q)
            3'd0:    word_sel = pack_word(res[0], res[1]);
            3'd1:    word_sel = pack_word(res[2], res[3]);
            3'd2:    word_sel = pack_word(res[4], res[5]);
            3'd3:    word_sel = pack_word(res[6], res[7]);
            3'd4:    word_sel = pack_word(res[8], '0);
            default: word_sel = '0;
        endcase
    end

    // Ack a fresh strobe; reads outside the serving window return zero.
    always_comb begin
        ack_d  = rd_stb && !ack_q;
        data_d = data_q;
        wp_d   = wp_q;
        last_d = 1'b0;
        if (ack_d) begin
            if (serve) begin
                data_d = word_sel;
                if (wp_q == 3'(NWORDS - 1)) begin
                    wp_d   = '0;
                    last_d = 1'b1;
                end else begin
                    wp_d = wp_q + 3'd1;
                end
            end else begin
                data_d = '0;
            end
        end
    end

    // Read port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            data_q <= '0;
            wp_q   <= '0;
            last_q <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            data_q <= data_d;
            wp_q   <= wp_d;
            last_q <= last_d;
        end
    end

    assign rd_ack   = ack_q;
    assign rd_data  = data_q;
    assign last_ack = last_q;

endmodule

// File: rtl/sa_result_collector.sv
// Captures the skewed 3x3 array column outputs and serves them as packed words.
module sa_result_collector
    import sa_result_collector_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    sa_result_collector_if.slave bus
);

    state_e      state_q, state_d;
    logic [2:0]  t_q, t_d;
    res_t        res_q [NRES];
    res_t        res_d [NRES];
    res_t        col [COLS];
    logic [2:0]  t_cur;
    logic        cap_en;
    logic        last_ack;

    assign col[0] = bus.out1;
    assign col[1] = bus.out2;
    assign col[2] = bus.out3;

    // State, capture counter and result buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            for (int unsigned i = 0; i < NRES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int unsigned i = 0; i < NRES; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start)              state_d = ST_ARMED;
            ST_ARMED:   if (bus.in_valid)           state_d = ST_CAPTURE;
            ST_CAPTURE: if (t_q == 3'(TLAST))       state_d = ST_READY;
            ST_READY:   if (last_ack)               state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Capture datapath: the in_valid edge in ARMED is t=0, so CAPTURE holds t=1..TLAST;
    // column c at time t delivers its row (t-c).
    always_comb begin
        cap_en = ((state_q == ST_ARMED) && bus.in_valid) || (state_q == ST_CAPTURE);
        t_cur  = (state_q == ST_CAPTURE) ? t_q : '0;
        t_d    = t_q;
        res_d  = res_q;
        if (cap_en) begin
            t_d = (t_cur == 3'(TLAST)) ? '0 : t_cur + 3'd1;
            for (int unsigned c = 0; c < COLS; c++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    if (t_cur == 3'(c + r)) begin
                        res_d[c*ROWS + r] = col[c];
                    end
                end
            end
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.busy  = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
        bus.ready = (state_q == ST_READY);
    end

    sa_rd_port u_rd_port (
        .clk      (clk),
        .rst      (rst),
        .rd_stb   (bus.rd_stb),
        .serve    (state_q == ST_READY),
        .res      (res_q),
        .rd_ack   (bus.rd_ack),
        .rd_data  (bus.rd_data),
        .last_ack (last_ack)
    );

endmodule

// File: tb/tb_sa_result_collector.sv
// Self-checking bench for sa_result_collector: per-cycle model compare plus directed literals.
module tb_sa_result_collector;
    import sa_result_collector_pkg::*;

    logic clk;
    logic rst;

    sa_result_collector_if bus ();

    sa_result_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State as small integers: 0 idle, 1 armed, 2 capturing, 3 ready.
    int          mst, mt, mwp, nst;
    bit          mack, mlast, nlast;
    logic [31:0] mdata;
    logic [15:0] mres [9];

    function automatic logic [31:0] mword(input int k);
        if (k < 4) return {mres[2*k+1], mres[2*k]};
        return {16'h0000, mres[8]};
    endfunction

    function automatic logic [15:0] colv(input int c);
        if (c == 0) return bus.out1;
        if (c == 1) return bus.out2;
        return bus.out3;
    endfunction

    initial begin
        mst = 0; mt = 0; mwp = 0; mack = 0; mlast = 0; mdata = '0;
        for (int i = 0; i < 9; i++) mres[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mst = 0; mt = 0; mwp = 0; mack = 0; mlast = 0; mdata = '0;
                for (int i = 0; i < 9; i++) mres[i] = '0;
            end else begin
                nst = mst;
                nlast = 0;
                if (mst == 0) begin
                    if (bus.start) nst = 1;
                end else if (mst == 1) begin
                    if (bus.in_valid) begin
                        mres[0] = bus.out1;
                        mt = 1;
                        nst = 2;
                    end
                end else if (mst == 2) begin
                    // frame time mt: column c presents its (mt-c)-th result
                    for (int c = 0; c < 3; c++)
                        if (mt - c >= 0 && mt - c < 3) mres[3*c + mt - c] = colv(c);
                    if (mt == 4) begin
                        mt = 0;
                        nst = 3;
                    end else begin
                        mt++;
                    end
                end else begin
                    if (mlast) nst = 0;
                end
                if (bus.rd_stb && !mack) begin
                    mack = 1;
                    if (mst == 3) begin
                        mdata = mword(mwp);
                        if (mwp == 4) begin
                            mwp = 0;
                            nlast = 1;
                        end else begin
                            mwp++;
                        end
                    end else begin
                        mdata = '0;
                    end
                end else begin
                    mack = 0;
                end
                mlast = nlast;
                mst = nst;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_rd_ack", {31'd0, bus.rd_ack}, {31'd0, mack});
                chk("cyc_rd_data", bus.rd_data, mdata);
                chk("cyc_busy", {31'd0, bus.busy}, {31'd0, (mst == 1 || mst == 2)});
                chk("cyc_ready", {31'd0, bus.ready}, {31'd0, (mst == 3)});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] fv [9];
    logic [31:0] exp_ramp [5];

    task automatic do_read(input logic [31:0] exp, input string nm);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        bus.rd_stb = 1'b1;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (bus.rd_ack) got = 1;
        end
        bus.rd_stb = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no rd_ack within 8 cycles, expected data %h", nm, exp);
        end else begin
            chk(nm, bus.rd_data, exp);
        end
    endtask

    // Drive one frame from fv; optionally check busy/ready timing, pulse start
    // mid-capture, or assert in_valid together with start in IDLE.
    task automatic frame(input bit tim, input bit start_mid, input bit same_iv);
        @(negedge clk);
        bus.start = 1'b1;
        if (same_iv) begin
            bus.in_valid = 1'b1;
            bus.out1 = 16'hDEAD;
        end
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (tim) begin
                chk("timing_busy", {31'd0, bus.busy}, {31'd0, (j <= 6)});
                chk("timing_ready", {31'd0, bus.ready}, {31'd0, (j == 7)});
            end
            bus.start    = start_mid && (j == 4);
            bus.in_valid = (j == 2);
            bus.out1 = (j == 2) ? fv[0] : (j == 3) ? fv[1] : (j == 4) ? fv[2] : 16'h0;
            bus.out2 = (j == 3) ? fv[3] : (j == 4) ? fv[4] : (j == 5) ? fv[5] : 16'h0;
            bus.out3 = (j == 4) ? fv[6] : (j == 5) ? fv[7] : (j == 6) ? fv[8] : 16'h0;
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 9; i++) fv[i] = 16'(i + 1);
    endtask

    initial begin
        int nack;
        exp_ramp[0] = 32'h00020001;
        exp_ramp[1] = 32'h00040003;
        exp_ramp[2] = 32'h00060005;
        exp_ramp[3] = 32'h00080007;
        exp_ramp[4] = 32'h00000009;

        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.rd_stb = 1'b0;
        bus.out1 = '0; bus.out2 = '0; bus.out3 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_rd_ack", {31'd0, bus.rd_ack}, 32'd0);
        chk("reset_rd_data", bus.rd_data, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b0;

        // read with nothing captured
        do_read(32'h0, "idle_read");

        // ramp frame with timing; first read must be word 0
        set_ramp();
        frame(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) do_read(exp_ramp[k], "ramp_word");
        @(negedge clk);
        chk("ramp_ready_after_drain", {31'd0, bus.ready}, 32'd0);
        do_read(32'h0, "read_after_drain");

        // start+in_valid together in IDLE, then held strobe for 10 cycles
        frame(1'b0, 1'b0, 1'b1);
        nack = 0;
        bus.rd_stb = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 10) bus.rd_stb = 1'b0;
            if (bus.rd_ack) begin
                if (nack < 5) chk("held_word", bus.rd_data, exp_ramp[nack]);
                nack++;
            end
        end
        chk("held_ack_count", 32'(nack), 32'd5);
        chk("held_ready_after", {31'd0, bus.ready}, 32'd0);
        do_read(32'h0, "held_idle_read");

        // start ignored during CAPTURE and during READY
        for (int i = 0; i < 9; i++) fv[i] = 16'hFFFF;
        frame(1'b0, 1'b1, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_ready_held", {31'd0, bus.ready}, 32'd1);
        for (int k = 0; k < 4; k++) do_read(32'hFFFFFFFF, "ign_word");
        do_read(32'h0000FFFF, "ign_word4");

        // reset mid-drain
        set_ramp();
        frame(1'b0, 1'b0, 1'b0);
        do_read(exp_ramp[0], "mid_word0");
        do_read(exp_ramp[1], "mid_word1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("mid_rst_rd_data", bus.rd_data, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 9; i++) fv[i] = 16'(16'h0101 * (i + 1));
        frame(1'b0, 1'b0, 1'b0);
        do_read(32'h02020101, "post_rst_word0");
        do_read(32'h04040303, "post_rst_word1");
        do_read(32'h06060505, "post_rst_word2");
        do_read(32'h08080707, "post_rst_word3");
        do_read(32'h00000909, "post_rst_word4");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_result_collector.md
Name: sa_result_collector

Overview:
- Downstream stage of the 3x3 systolic array (sysa).
- Samples the three skewed column outputs (out1/out2/out3) into a 9-entry, 16-bit result buffer.
- Serves the buffer as five packed 32-bit words over a simple strobe/ack read port, which the Wishbone front end forwards to caravel_wb_dat_o.
- Replaces the ad-hoc c1/c2/c3 result capture with a self-contained, verifiable stage.

Parameters:
- ROWS, 3, results per column (array height)
- COLS, 3, number of columns (array width)
- DW, 16, result width per array output

Ports:
- clk  in  1  block clock (same clock as sysa)
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: arm a new capture; honoured only in IDLE
- in_valid  in  1  asserted by the array on the cycle column 0 presents its first valid result
- out1  in  DW  column 0 result
- out2  in  DW  column 1 result, lags column 0 by 1 cycle
- out3  in  DW  column 2 result, lags column 0 by 2 cycles
- rd_stb  in  1  read request; held high until rd_ack
- rd_ack  out  1  one-cycle read acknowledge
- rd_data  out  32  packed result word; valid while rd_ack=1
- busy  out  1  high in ARMED or CAPTURE
- ready  out  1  high in READY (buffer full, undrained)

Behaviour:
- Reset values: rd_ack=0, rd_data=0, busy=0, ready=0, state=IDLE, all 9 buffer entries=0, capture counter t=0, word pointer wp=0.
- FSM states:
  - IDLE: on start go to ARMED. in_valid and rd_stb are ignored for capture.
  - ARMED: on in_valid go to CAPTURE. The same edge is t=0 and samples out1 into res[0].
  - CAPTURE: t counts 0..ROWS+COLS-2 (0..4). At each edge, column c (0..2) with c <= t <= c+ROWS-1 writes res[c*ROWS + (t-c)]. For t=4 the next state is READY. in_valid is not re-checked; the array stream is contiguous.
  - READY: serves reads. After word 4 is acked, go to IDLE with wp=0.
- Index map: column 0 -> res[0..2], column 1 -> res[3..5], column 2 -> res[6..8].
- Latency:
  - ready rises on the cycle after the t=4 sample, i.e. 5 cycles after the in_valid edge.
  - busy rises on the cycle after start and falls together with ready rising.
- Packing (little end first):
  - word k (k=0..3) = {res[2k+1], res[2k]}
  - word 4 = {16'h0000, res[8]}
- Read handshake:
  - The cycle after rd_stb is sampled high with rd_ack low, rd_ack=1 for exactly one cycle, rd_data=word[wp], and wp increments.
  - No ack on the cycle immediately following an ack, even if rd_stb stays high. Maximum rate is one word per 2 cycles.
- Reads outside READY: ack as normal with rd_data=0. wp does not advance and state does not change, so the bus never hangs.
- When rd_ack is low, rd_data holds its last value.
- Boundary conditions:
  - start in ARMED, CAPTURE or READY is ignored. A new capture requires the full drain.
  - start and in_valid in the same cycle in IDLE: only the transition to ARMED occurs; that in_valid is not captured.
  - Buffer contents persist through IDLE until the next CAPTURE overwrites them.
  - Reset mid-capture or mid-drain returns everything to its reset value on the next edge.
- Arithmetic: no arithmetic on data, which is stored bit-exact. t is 3 bits, wp is 3 bits; neither wraps within one frame.

Decomposition:
- Shared package tpu_pkg: ROWS, COLS, DW, NWORDS=5, and the state encodings (IDLE=0, ARMED=1, CAPTURE=2, READY=3).
- Natural sub-module: sa_rd_port, holding the strobe/ack generator, wp counter and word packing mux. The parent keeps the FSM and the buffer.

Test Plan:
- Ramp frame: start, then in_valid. out1=1,2,3 at t=0..2; out2=4,5,6 at t=1..3; out3=7,8,9 at t=2..4. Five reads -> 0x00020001, 0x00040003, 0x00060005, 0x00080007, 0x00000009. ready falls after the 5th ack; state is IDLE.
- Timing: start at cycle 10, in_valid at cycle 12 -> busy high cycles 11..16, ready rises at cycle 17.
- Idle read: rd_stb with no frame captured -> rd_ack one cycle later, rd_data=0. A following full frame reads word 0 first (wp not advanced).
- Held strobe: rd_stb held high for 10 cycles in READY -> acks on alternate cycles, 5 acks with the correct words. Then reads return 0 in IDLE.
- Ignored events: start pulsed during CAPTURE and again during READY. Buffer must be unchanged: all values 0xFFFF -> read words 0xFFFFFFFF x4, then 0x0000FFFF.
- Reset mid-drain: after 2 words read, assert rst for 1 cycle -> ready=0, rd_data=0. A new frame of values 0x0101..0x0909 reads from word 0, first word 0x02020101.
